rtc_alarm_servicer: RTL
=======================

# rtc_alarm_servicer

Hardware responder for the RTC alarm interrupt: it watches the masked RTC interrupt line and services it autonomously over APB, with no CPU involvement. On each alarm it confirms the source, clears the interrupt, reads the current count, and either re-arms the match register for a periodic alarm or masks the interrupt for a one-shot alarm. It sits beside the CPU as a second APB initiator in front of the RTC register slice and drives the interrupt-clear and match-register writes that the RTC's interrupt logic consumes.

## Interface
Parameters:
- ADDR_W, 12: APB byte-address width.
- CNT_W, 16: width of AlarmCount.

Ports (one clock; reset is asynchronous and active-high):
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- RTCINTR  in  1  masked RTC interrupt, level, PCLK-synchronous.
- Enable  in  1  service enable; sampled only in IDLE.
- Period  in  32  re-arm increment in seconds; 0 selects one-shot.
- ErrClr  in  1  clears the Error flag.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB byte address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB wait-state control.
- PSLVERR  in  1  APB error response.
- AlarmPulse  out  1  one-cycle strobe per serviced alarm.
- AlarmCount  out  CNT_W  serviced alarms, wraps modulo 2^CNT_W.
- Busy  out  1  high in any state other than IDLE.
- Error  out  1  sticky APB error flag.

## Operation
- Register offsets used: RTCDR 0x000, RTCMR 0x004, RTCIMSC 0x010, RTCMIS 0x018, RTCICR 0x01C.
- States:
  - IDLE → RD_MIS when Enable & RTCINTR.
  - RD_MIS: if PRDATA[0]=0 (spurious), go to IDLE; otherwise go to WR_ICR.
  - WR_ICR writes 0x1, then RD_DR.
  - RD_DR latches the count, then WR_MR if Period≠0, or WR_IMSC if Period=0.
  - WR_MR writes count+Period, modulo 2^32, wrapping at 0xFFFFFFFF.
  - WR_IMSC writes 0x0.
  - Both WR_MR and WR_IMSC go to DONE. DONE → IDLE.
- Period is sampled in RD_DR.
- Reprogramming RTCMR, or masking via RTCIMSC, is mandatory: the raw match stays true while count equals match, so clearing RTCICR alone does not drop RTCINTR.
- DONE asserts AlarmPulse and increments AlarmCount.
- A PSLVERR on any transfer completion sets Error and returns to IDLE with no pulse and no count increment. Error stays set until ErrClr or reset. While Error=1, IDLE does not start new sequences.
- Deasserting Enable mid-sequence does not abort; the sequence runs to DONE.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, AlarmPulse, AlarmCount, Busy and Error are all 0; state is IDLE.
- Each APB transfer: setup cycle (PSEL=1, PENABLE=0), then access cycles (PSEL=1, PENABLE=1) until PREADY=1. PADDR, PWRITE and PWDATA are stable across both phases.
- Transfers are back-to-back: the next transfer's setup follows its predecessor's completing access cycle.
- Zero wait states, trigger sampled at edge N:
  - setups at N+1, N+3, N+5, N+7;
  - AlarmPulse during cycle N+9;
  - IDLE from N+10;
  - RTCINTR is re-evaluated from cycle N+10.
- Each wait state adds exactly one cycle.
- PRDATA is captured only on the completing access cycle.
- PRESET asserted mid-transfer drops PSEL and PENABLE immediately (asynchronously). No partial write is retried after reset.

## Structure
- Package rtc_pkg holds:
  - register offset constants (RTCDR_OFS, RTCMR_OFS, RTCIMSC_OFS, RTCMIS_OFS, RTCICR_OFS);
  - the state enum.
- Sub-module rtc_apb_xfer: a single-transfer APB engine.
  - Inputs: start, write, addr, wdata.
  - Outputs: done, rdata, err, plus the APB pins.
- The top level is the sequencing state machine only.

## Test plan
- Enable=1, Period=60, RTCINTR rises, MIS reads 0x1, DR reads 0x0000_1000, PREADY=1 → writes ICR=0x1 and MR=0x0000_103C; AlarmPulse at N+9; AlarmCount 0→1.
- Period=0 → writes IMSC=0x0 instead of MR; AlarmPulse asserted.
- DR reads 0xFFFF_FFF0, Period=0x20 → MR write data 0x0000_0010.
- MIS reads 0x0 → no ICR write; IDLE at N+3; no pulse.
- PREADY held low for 3 cycles on the ICR write → PWDATA and PADDR stable throughout; pulse moves from N+9 to N+12.
- PSLVERR on the DR read → Error=1, IDLE, no pulse; RTCINTR ignored until ErrClr.
- PRESET asserted at N+4 → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC alarm servicer: register offsets and sequencer states.
package rtc_pkg;

  localparam logic [11:0] RTCDR_OFS   = 12'h000;
  localparam logic [11:0] RTCMR_OFS   = 12'h004;
  localparam logic [11:0] RTCIMSC_OFS = 12'h010;
  localparam logic [11:0] RTCMIS_OFS  = 12'h018;
  localparam logic [11:0] RTCICR_OFS  = 12'h01C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_MIS,
    S_WR_ICR,
    S_RD_DR,
    S_WR_MR,
    S_WR_IMSC,
    S_DONE
  } state_t;

endpackage

// File: rtl/rtc_apb_xfer.sv
// Single-transfer APB initiator. A start accepted while idle, or on the
// completing access cycle, launches the next setup phase with no gap.
module rtc_apb_xfer
  import rtc_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Completion is the access cycle that sees PREADY; read data is only
  // meaningful to the sequencer in that cycle.
  assign done  = psel & penable & pready;
  assign err   = done & pslverr;
  assign rdata = prdata;

  // Setup -> access -> (wait)* -> complete; address/data held for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (start && (!psel || done)) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= write;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else if (done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_alarm_servicer.sv
// Autonomous RTC alarm handler: confirm, clear, read count, then re-arm or mask.
module rtc_alarm_servicer
  import rtc_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              RTCINTR,
  input  logic              Enable,
  input  logic [31:0]       Period,
  input  logic              ErrClr,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              AlarmPulse,
  output logic [CNT_W-1:0]  AlarmCount,
  output logic              Busy,
  output logic              Error
);

  state_t            state;
  logic              start, write, done, err, ok;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, rdata;

  assign ok = done & ~err;

  rtc_apb_xfer #(.ADDR_W(ADDR_W)) u_xfer (
    .clk     (PCLK),
    .rst     (PRESET),
    .start   (start),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

  // Next-transfer request: issued on the completing cycle of the previous
  // transfer so transfers run back-to-back. The re-arm value is formed from
  // the count on the DR completion and held by the engine as PWDATA.
  always_comb begin
    start = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state)
      S_RD_MIS: begin
        if (!PSEL) begin
          start = 1'b1;
          addr  = ADDR_W'(RTCMIS_OFS);
        end else if (ok && rdata[0]) begin
          start = 1'b1;
          write = 1'b1;
          addr  = ADDR_W'(RTCICR_OFS);
          wdata = 32'h1;
        end
      end
      S_WR_ICR: begin
        if (ok) begin
          start = 1'b1;
          addr  = ADDR_W'(RTCDR_OFS);
        end
      end
      S_RD_DR: begin
        if (ok) begin
          start = 1'b1;
          write = 1'b1;
          if (Period != 32'd0) begin
            addr  = ADDR_W'(RTCMR_OFS);
            wdata = rdata + Period;
          end else begin
            addr  = ADDR_W'(RTCIMSC_OFS);
            wdata = 32'h0;
          end
        end
      end
      default: ;
    endcase
  end

  // Sequencer with registered status outputs; any slave error aborts to IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= S_IDLE;
      AlarmPulse <= 1'b0;
      AlarmCount <= '0;
      Busy       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      AlarmPulse <= 1'b0;
      if (err)         Error <= 1'b1;
      else if (ErrClr) Error <= 1'b0;

      if (err) begin
        state <= S_IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Enable && RTCINTR && !Error) begin
              state <= S_RD_MIS;
              Busy  <= 1'b1;
            end
          end
          S_RD_MIS: begin
            if (done) begin
              if (rdata[0]) begin
                state <= S_WR_ICR;
              end else begin
                state <= S_IDLE;
                Busy  <= 1'b0;
              end
            end
          end
          S_WR_ICR: if (done) state <= S_RD_DR;
          S_RD_DR:  if (done) state <= (Period != 32'd0) ? S_WR_MR : S_WR_IMSC;
          S_WR_MR, S_WR_IMSC: begin
            if (done) begin
              state      <= S_DONE;
              AlarmPulse <= 1'b1;
              AlarmCount <= AlarmCount + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
